// File: rtl/axis_demux_1x2_if.sv
// Single AXI-Stream link (data, valid, ready, last) with producer/consumer views.
interface axis_demux_1x2_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_demux_1x2.sv
// Packet-aware 1-to-2 AXI-Stream demux; AXIS_DEMUX_PKT_LOCK_EN pins whole packets to the first beat's select.
// Latency: 1 cycle, fully registered outputs. Backpressure: 2-entry head/skid buffer, registered s_axis.tready.
// A stalled destination blocks both ports; beats leave strictly in acceptance order.
module axis_demux_1x2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    select,
    axis_demux_1x2_if.slave         s_axis,
    axis_demux_1x2_if.master        m_axis_1,
    axis_demux_1x2_if.master        m_axis_2
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  dest;
    } entry_t;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_beat;
    logic   head_vld_q, head_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   rdy_q, rdy_d;
    logic   accept;
    logic   drain;
    logic   beat_dest;

    assign accept = s_axis.tvalid && rdy_q;
    assign drain  = head_vld_q && (head_q.dest ? m_axis_2.tready : m_axis_1.tready);

`ifdef AXIS_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state_q, state_d;
    logic   lock_dest_q, lock_dest_d;

    always_comb begin
        state_d     = state_q;
        lock_dest_d = lock_dest_q;
        beat_dest   = select;
        case (state_q)
            IDLE: begin
                if (accept && !s_axis.tlast) begin
                    state_d     = LOCKED;
                    lock_dest_d = select;
                end
            end
            LOCKED: begin
                beat_dest = lock_dest_q;
                if (accept && s_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lock_dest_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_dest_q <= lock_dest_d;
        end
    end
`else
    assign beat_dest = select;
`endif

    assign in_beat = {s_axis.tdata, s_axis.tlast, beat_dest};

    // Registered ready means accept never coincides with a full skid.
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (drain) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!head_vld_q || drain) begin
                head_d     = in_beat;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end else if (drain) begin
            head_vld_d = 1'b0;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_axis.tready   = rdy_q;

    assign m_axis_1.tvalid = head_vld_q && !head_q.dest;
    assign m_axis_1.tdata  = head_q.data;
    assign m_axis_1.tlast  = head_q.last;

    assign m_axis_2.tvalid = head_vld_q && head_q.dest;
    assign m_axis_2.tdata  = head_q.data;
    assign m_axis_2.tlast  = head_q.last;

endmodule

// File: tb/tb_axis_demux_1x2.sv
// Bench for axis_demux_1x2: directed packet scenarios then random traffic against an in-order beat model.
module tb_axis_demux_1x2;
    localparam int DW = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic select  = 1'b0;

    always #5 clk = ~clk;

    axis_demux_1x2_if #(.DATA_WIDTH(DW)) s_if ();
    axis_demux_1x2_if #(.DATA_WIDTH(DW)) m1_if ();
    axis_demux_1x2_if #(.DATA_WIDTH(DW)) m2_if ();

    axis_demux_1x2 #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .select   (select),
        .s_axis   (s_if),
        .m_axis_1 (m1_if),
        .m_axis_2 (m2_if)
    );

    typedef struct {
        logic          dest;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } obs_t;

    beat_t mq[$];       // beats held inside the DUT, oldest first
    obs_t  log_q[$];    // beats observed leaving the DUT
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    n_in   = 0;
    int    n_out  = 0;
    logic  rdy_exp = 1'b0;
    logic  in_pkt  = 1'b0;
    logic  pkt_dest = 1'b0;
    int    r1_lo = 0, r1_hi = 0, r2_lo = 0, r2_hi = 0;
    logic  saw_rdy_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic route(input logic sel, input logic lst);
        logic d;
`ifdef AXIS_DEMUX_PKT_LOCK_EN
        d        = in_pkt ? pkt_dest : sel;
        pkt_dest = d;
        in_pkt   = !lst;
`else
        d = sel;
`endif
        return d;
    endfunction

    task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic lst,
                         input logic sel, input logic r1, input logic r2, output logic acc);
        logic drain;
        s_if.tvalid   = vld;
        s_if.tdata    = d;
        s_if.tlast    = lst;
        select        = sel;
        m1_if.tready  = r1;
        m2_if.tready  = r2;
        @(negedge clk);
        chk("s_tready", s_if.tready, rdy_exp);
        if (s_if.tready !== 1'b1) saw_rdy_low = 1'b1;
        if (mq.size() > 0) begin
            chk("tvalid_1", m1_if.tvalid, mq[0].dest == 1'b0);
            chk("tvalid_2", m2_if.tvalid, mq[0].dest == 1'b1);
            chk("tdata_1", m1_if.tdata, mq[0].data);
            chk("tdata_2", m2_if.tdata, mq[0].data);
            chk("tlast_1", m1_if.tlast, mq[0].last);
            chk("tlast_2", m2_if.tlast, mq[0].last);
        end else begin
            chk("tvalid_1_idle", m1_if.tvalid, 0);
            chk("tvalid_2_idle", m2_if.tvalid, 0);
        end
        if (m1_if.tvalid === 1'b1 && r1) begin
            log_q.push_back('{1, m1_if.tdata, m1_if.tlast});
            n_out++;
        end
        if (m2_if.tvalid === 1'b1 && r2) begin
            log_q.push_back('{2, m2_if.tdata, m2_if.tlast});
            n_out++;
        end
        drain = 1'b0;
        if (mq.size() > 0) drain = mq[0].dest ? r2 : r1;
        acc = vld && rdy_exp;
        if (drain) void'(mq.pop_front());
        if (acc) begin
            mq.push_back('{route(sel, lst), d, lst});
            n_in++;
        end
        rdy_exp = (mq.size() < 2);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic rdy_at(input int lo, input int hi);
        return !(cyc >= lo && cyc < hi);
    endfunction

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            cycle(1'b0, '0, 1'b0, select, rdy_at(r1_lo, r1_hi), rdy_at(r2_lo, r2_hi), acc);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic lst, input logic sel);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++)
            cycle(1'b1, d, lst, sel, rdy_at(r1_lo, r1_hi), rdy_at(r2_lo, r2_hi), acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic do_reset();
        s_if.tvalid  = 1'b0;
        m1_if.tready = 1'b1;
        m2_if.tready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_tvalid_1", m1_if.tvalid, 0);
        chk("rst_tvalid_2", m2_if.tvalid, 0);
        chk("rst_tdata_1", m1_if.tdata, 0);
        chk("rst_tdata_2", m2_if.tdata, 0);
        chk("rst_tready", s_if.tready, 0);
        mq.delete();
        in_pkt  = 1'b0;
        rdy_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_log(input string tag, input int idx, input int port,
                           input logic [DW-1:0] d, input logic lst);
        if (idx < log_q.size()) begin
            chk({tag, "_port"}, log_q[idx].port, port);
            chk({tag, "_data"}, log_q[idx].data, d);
            chk({tag, "_last"}, log_q[idx].last, lst);
        end else begin
            chk({tag, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    initial begin
        logic acc;
        logic [DW-1:0] bp_d [8];
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
        m1_if.tready = 1'b1; m2_if.tready = 1'b1;

        // Reset and first-edge ready
        do_reset();
        idle(1);
        chk("tready_after_release", s_if.tready, 1);
        idle(1);

        // Streaming to port 1
        log_q.delete();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        send(8'h08, 1'b1, 1'b0);
        idle(3);
        chk("stream_count", log_q.size(), 4);
        chk_log("stream0", 0, 1, 8'h01, 1'b0);
        chk_log("stream1", 1, 1, 8'h02, 1'b0);
        chk_log("stream2", 2, 1, 8'h04, 1'b0);
        chk_log("stream3", 3, 1, 8'h08, 1'b1);

        // Select change mid-packet
        log_q.delete();
        send(8'h03, 1'b0, 1'b0);
        send(8'h09, 1'b0, 1'b1);
        send(8'h1B, 1'b1, 1'b1);
        send(8'h05, 1'b1, 1'b1);
        idle(3);
`ifdef AXIS_DEMUX_PKT_LOCK_EN
        chk_log("midsel0", 0, 1, 8'h03, 1'b0);
        chk_log("midsel1", 1, 1, 8'h09, 1'b0);
        chk_log("midsel2", 2, 1, 8'h1B, 1'b1);
`else
        chk_log("midsel0", 0, 1, 8'h03, 1'b0);
        chk_log("midsel1", 1, 2, 8'h09, 1'b0);
        chk_log("midsel2", 2, 2, 8'h1B, 1'b1);
`endif
        chk_log("midsel3", 3, 2, 8'h05, 1'b1);

        // Back-pressure on port 1 for 3 cycles during a continuous stream
        log_q.delete();
        saw_rdy_low = 1'b0;
        r1_lo = cyc + 2; r1_hi = cyc + 5;
        for (int i = 0; i < 8; i++) begin
            bp_d[i] = 8'(8'h40 + i);
            send(bp_d[i], i == 7, 1'b0);
        end
        idle(4);
        chk("bp_tready_dropped", saw_rdy_low, 1);
        chk("bp_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_log("bp", i, 1, bp_d[i], i == 7);

        // Head-of-line blocking: A to stalled port 2, B to port 1 behind it
        log_q.delete();
        r2_lo = cyc; r2_hi = cyc + 8;
        send(8'hA1, 1'b0, 1'b1);
        send(8'hA2, 1'b1, 1'b1);
        send(8'hB1, 1'b1, 1'b0);
        idle(10);
        chk("hol_count", log_q.size(), 3);
        chk_log("hol0", 0, 2, 8'hA1, 1'b0);
        chk_log("hol1", 1, 2, 8'hA2, 1'b1);
        chk_log("hol2", 2, 1, 8'hB1, 1'b1);

        // Reset after beat 2 of 4; next packet routes from its own first beat
        send(8'h61, 1'b0, 1'b1);
        send(8'h62, 1'b0, 1'b1);
        do_reset();
        idle(2);
        log_q.delete();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b1);
        idle(3);
        chk_log("rstpkt0", 0, 1, 8'h11, 1'b0);
`ifdef AXIS_DEMUX_PKT_LOCK_EN
        chk_log("rstpkt1", 1, 1, 8'h22, 1'b1);
`else
        chk_log("rstpkt1", 1, 2, 8'h22, 1'b1);
`endif

        // Random traffic, then drain and compare totals
        n_in = 0; n_out = 0;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                  1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        chk("rand_beats_out", n_out, n_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_demux_1x2.md
# axis_demux_1x2

- Packet-aware 1-to-2 AXI-Stream demultiplexer: the splitting counterpart of `axis_mux`.
- Accepts one slave stream and routes each packet, whole, to master port 1 or 2 according to `select`.
- Includes a 2-entry skid buffer, so the output is fully registered and back-pressure is absorbed without combinational ready paths.
- Sits where one producer feeds two consumer pipelines.

## Interface
Parameters:
- DATA_WIDTH, 8, width of tdata on all ports

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  input beat data
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready; registered
- s_axis_tlast  in  1  last beat of input packet
- select  in  1  destination; 0 = port 1, 1 = port 2
- m_axis_tdata_1 / m_axis_tdata_2  out  DATA_WIDTH  output data; both carry the head-register data
- m_axis_tvalid_1 / m_axis_tvalid_2  out  1  output valid; at most one is high at a time
- m_axis_tready_1 / m_axis_tready_2  in  1  output ready
- m_axis_tlast_1 / m_axis_tlast_2  out  1  output last; both carry the head-register tlast

## Operation
**Storage**
- Two entries: head and skid. Each holds {data, last, dest}.
- Accept: `s_axis_tvalid && s_axis_tready`.
- Drain: head valid && `m_axis_tready_<head.dest>`.

**Destination lock (FSM)**
- IDLE: the accepted beat takes `dest = select`.
  - If its tlast = 0, go to LOCKED with `lock_dest = select`.
  - If its tlast = 1, stay in IDLE (single-beat packet).
- LOCKED: accepted beats take `dest = lock_dest`; `select` is ignored. An accepted beat with tlast = 1 returns the FSM to IDLE.

**Buffer moves**
- Accept into the head when the head is empty or draining this cycle; otherwise accept into the skid.
- Skid occupied and head draining: the skid moves to the head.
- `s_axis_tready` next = NOT (skid valid after this cycle's update). It deasserts the cycle after the skid fills.
- Accept and drain in the same cycle with an empty skid: head is overwritten; no bubble.

**Outputs**
- `m_axis_tvalid_1` = head valid && dest = 0; `m_axis_tvalid_2` = head valid && dest = 1.
- Both tdata/tlast outputs always drive the head contents.
- A stalled port blocks both ports: delivery is strictly in order and there is no reordering.

## Timing
- Latency: a beat accepted at edge N is visible on the master port after edge N (1 cycle).
- Throughput: 1 beat/cycle while the destination tready is high.
- Reset (asynchronous assert): head and skid invalid; all m_axis outputs 0; `s_axis_tready` = 0; FSM = IDLE.
  - `s_axis_tready` rises at the first clk edge after `reset_n` deasserts.
- Reset mid-packet: the packet is discarded and the FSM returns to IDLE. No partial-packet recovery.
- `select` changing mid-packet: no effect until the next packet's first accepted beat.
- Output stability: once a master tvalid is high, data/last/valid hold until the drain.

## Configuration
- `AXIS_DEMUX_PKT_LOCK_EN` defined: packet lock as above.
- Undefined: no FSM; every accepted beat takes `dest = select` at acceptance, regardless of tlast.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles -> all m_axis_tvalid = 0, tdata = 0, `s_axis_tready` = 0; tready = 1 one edge after release.
- Streaming to port 1: select = 0, both treadys = 1, beats 0x01, 0x02, 0x04, 0x08 (last on 0x08) -> same sequence on port 1 one cycle later, tlast_1 on 0x08, tvalid_2 never high.
- Mid-packet select change: select = 0 at the first beat (0x03), select = 1 from beat 2, packet 0x03/0x09/0x1B with last on 0x1B -> all three beats on port 1; next packet 0x05 (last) -> port 2.
  - Without the macro, 0x09 and 0x1B go to port 2.
- Back-pressure: `m_axis_tready_1` = 0 for 3 cycles during a continuous stream -> skid fills, `s_axis_tready` drops one cycle later; no beat lost or duplicated; order preserved after tready returns.
- Head-of-line blocking: packet A to port 2 with `m_axis_tready_2` = 0, packet B to port 1 behind it -> port 1 gets nothing until A drains.
- Reset mid-packet: assert `reset_n` = 0 after beat 2 of 4 -> outputs clear immediately; the next packet routes per its own first-beat select.
